// File: rtl/i2c_pkg.sv
// Shared types for the I2C register slave: FSM state encoding and ACK/NACK bus levels.
`timescale 1ns/1ps
package i2c_pkg;
    typedef enum logic [2:0] {
        IDLE, ADDR, A_ACK, PTR_RX, W_ACK, WR_RX, RD_TX, RD_MACK
    } i2c_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;
endpackage

// File: rtl/i2c_bus_monitor.sv
// SCL/SDA synchroniser with one history flop; produces SCL edge pulses and START/STOP pulses.
`timescale 1ns/1ps
module i2c_bus_monitor #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic scl,
    input  logic sda,
    output logic sda_s,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);
    logic [SYNC_STAGES-1:0] scl_sync_p0;
    logic [SYNC_STAGES-1:0] sda_sync_p0;
    logic                   scl_d_p1;
    logic                   sda_d_p1;
    logic                   scl_s;

    // Reset to the idle bus level so leaving reset never fakes a START
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scl_sync_p0 <= '1;
            sda_sync_p0 <= '1;
            scl_d_p1    <= 1'b1;
            sda_d_p1    <= 1'b1;
        end else begin
            scl_sync_p0 <= {scl_sync_p0[SYNC_STAGES-2:0], scl};
            sda_sync_p0 <= {sda_sync_p0[SYNC_STAGES-2:0], sda};
            scl_d_p1    <= scl_sync_p0[SYNC_STAGES-1];
            sda_d_p1    <= sda_sync_p0[SYNC_STAGES-1];
        end
    end

    assign scl_s    = scl_sync_p0[SYNC_STAGES-1];
    assign sda_s    = sda_sync_p0[SYNC_STAGES-1];
    assign scl_rise = scl_s & ~scl_d_p1;
    assign scl_fall = ~scl_s & scl_d_p1;
    assign start    = scl_s & scl_d_p1 & sda_d_p1 & ~sda_s;
    assign stop     = scl_s & scl_d_p1 & ~sda_d_p1 & sda_s;
endmodule

// File: rtl/i2c_reg_slave.sv
// I2C slave exposing NUM_REGS byte registers: pointer write, data write and snapshot read,
// both with wrapping auto-increment.
`timescale 1ns/1ps
module i2c_reg_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0] I2C_ADDR    = 7'h64,
    parameter int         NUM_REGS    = 8,
    parameter int         SYNC_STAGES = 2,
    localparam int        PTR_W       = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  scl,
    input  logic                  sda_in,
    output logic                  sda_oe,
    output logic                  sda_out,
    input  logic [8*NUM_REGS-1:0] rd_data,
    output logic                  wr_en,
    output logic [PTR_W-1:0]      wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);
    logic sda_s, scl_rise, scl_fall, start, stop;

    i2c_bus_monitor #(.SYNC_STAGES(SYNC_STAGES)) u_mon (
        .clk      (clk),
        .rst_n    (rst_n),
        .scl      (scl),
        .sda      (sda_in),
        .sda_s    (sda_s),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    i2c_state_t            state, state_n;
    logic [3:0]            bit_cnt, bit_cnt_n;
    logic [7:0]            shift, shift_n;
    logic [7:0]            tx, tx_n;
    logic [PTR_W-1:0]      ptr, ptr_n;
    logic                  sda_oe_n, wr_en_n, snap;
    logic [PTR_W-1:0]      wr_addr_n;
    logic [7:0]            wr_data_n;
    logic [8*NUM_REGS-1:0] image;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_REGS - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [7:0] get_byte(input logic [8*NUM_REGS-1:0] img,
                                            input logic [PTR_W-1:0] idx);
        return img[8*idx +: 8];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            ptr     <= '0;
            sda_oe  <= 1'b0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            ptr     <= ptr_n;
            sda_oe  <= sda_oe_n;
            wr_en   <= wr_en_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
        end
    end

    // Byte datapath carries no reset; its contents are always rewritten before use
    always_ff @(posedge clk) begin
        shift <= shift_n;
        tx    <= tx_n;
        if (snap) image <= rd_data;
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        tx_n      = tx;
        ptr_n     = ptr;
        sda_oe_n  = sda_oe;
        wr_en_n   = 1'b0;
        wr_addr_n = wr_addr;
        wr_data_n = wr_data;
        snap      = 1'b0;
        if (start) begin
            state_n   = ADDR;
            bit_cnt_n = '0;
            sda_oe_n  = 1'b0;
        end else if (stop) begin
            state_n  = IDLE;
            sda_oe_n = 1'b0;
        end else begin
            case (state)
                ADDR, PTR_RX, WR_RX: begin
                    if (scl_rise && bit_cnt != 4'd8) begin
                        shift_n   = {shift[6:0], sda_s};
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall && bit_cnt == 4'd8) begin
                        // The fall ending the 8th bit opens the ACK slot
                        bit_cnt_n = '0;
                        if (state == ADDR) begin
                            if (shift[7:1] == I2C_ADDR) begin
                                sda_oe_n = 1'b1;
                                state_n  = A_ACK;
                            end else begin
                                state_n = IDLE;
                            end
                        end else if (state == PTR_RX) begin
                            if ({1'b0, shift} < 9'(NUM_REGS)) begin
                                ptr_n    = shift[PTR_W-1:0];
                                sda_oe_n = 1'b1;
                                state_n  = W_ACK;
                            end else begin
                                state_n = IDLE;
                            end
                        end else begin
                            wr_en_n   = 1'b1;
                            wr_addr_n = ptr;
                            wr_data_n = shift;
                            ptr_n     = next_ptr(ptr);
                            sda_oe_n  = 1'b1;
                            state_n   = W_ACK;
                        end
                    end
                end
                A_ACK: begin
                    if (scl_fall) begin
                        bit_cnt_n = '0;
                        if (shift[0]) begin
                            snap     = 1'b1;
                            tx_n     = get_byte(rd_data, ptr);
                            sda_oe_n = ~tx_n[7];
                            state_n  = RD_TX;
                        end else begin
                            sda_oe_n = 1'b0;
                            state_n  = PTR_RX;
                        end
                    end
                end
                W_ACK: begin
                    if (scl_fall) begin
                        sda_oe_n = 1'b0;
                        state_n  = WR_RX;
                    end
                end
                RD_TX: begin
                    // bit_cnt counts rises; each fall presents bit 7-bit_cnt
                    if (scl_rise) begin
                        bit_cnt_n = bit_cnt + 4'd1;
                    end else if (scl_fall) begin
                        if (bit_cnt == 4'd8) begin
                            sda_oe_n = 1'b0;
                            state_n  = RD_MACK;
                        end else begin
                            sda_oe_n = ~tx[~bit_cnt[2:0]];
                        end
                    end
                end
                RD_MACK: begin
                    if (scl_rise) begin
                        ptr_n     = next_ptr(ptr);
                        bit_cnt_n = '0;
                        if (sda_s == I2C_ACK) begin
                            tx_n    = get_byte(image, next_ptr(ptr));
                            state_n = RD_TX;
                        end else begin
                            state_n = IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda_out = 1'b0;
    assign busy    = (state != IDLE);
endmodule

// File: tb/tb_i2c_reg_slave.sv
// Directed bench for i2c_reg_slave: a timed I2C master drives an open-drain bus model.
`timescale 1ns/1ps
module tb_i2c_reg_slave;
    localparam int T = 60;  // quarter of an SCL bit, 6 system clocks

    logic        clk, rst_n, scl, sda_m;
    logic        sda_line, sda_oe, sda_out, wr_en, busy;
    logic [63:0] rd_data;
    logic [2:0]  wr_addr;
    logic [7:0]  wr_data;

    int          compared = 0;
    int          mismatched = 0;
    int          wr_cnt = 0;
    int          oe_cnt = 0;
    logic [7:0]  wr_a [16];
    logic [7:0]  wr_d [16];

    i2c_reg_slave dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .scl     (scl),
        .sda_in  (sda_line),
        .sda_oe  (sda_oe),
        .sda_out (sda_out),
        .rd_data (rd_data),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .busy    (busy)
    );

    assign sda_line = (sda_oe ? sda_out : 1'b1) & sda_m;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en && wr_cnt < 16) begin
            wr_a[wr_cnt] = {5'b0, wr_addr};
            wr_d[wr_cnt] = wr_data;
            wr_cnt++;
        end
        if (sda_oe) oe_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; #(T);
        scl = 1'b1;   #(T);
        sda_m = 1'b0; #(T);
        scl = 1'b0;   #(T);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; #(T);
        scl = 1'b1;   #(T);
        sda_m = 1'b1; #(T);
    endtask

    task automatic clock_bit(input logic b, output logic s);
        sda_m = b;  #(T);
        scl = 1'b1; #(T);
        s = sda_line; #(T);
        scl = 1'b0; #(T);
    endtask

    task automatic i2c_write(input logic [7:0] v, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) clock_bit(v[i], s);
        clock_bit(1'b1, ack);
    endtask

    task automatic i2c_read(input logic mack, input bit hook, output logic [7:0] v);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            if (hook && i == 4) rd_data[15:8] = 8'h99;
            clock_bit(1'b1, s);
            v[i] = s;
        end
        clock_bit(mack, s);
    endtask

    initial begin
        logic       ack;
        logic [7:0] b;
        int         base, oe_base;
        scl = 1'b1; sda_m = 1'b1; rd_data = '0; rst_n = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("rst_sda_oe", sda_oe, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_addr", wr_addr, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_busy", busy, 0);
        check("rst_ptr", dut.ptr, 0);

        // 1: write two data bytes from pointer 2
        base = wr_cnt;
        i2c_start();
        i2c_write(8'hC8, ack); check("t1_addr_ack", ack, 0);
        check("t1_busy", busy, 1);
        i2c_write(8'h02, ack); check("t1_ptr_ack", ack, 0);
        i2c_write(8'hAA, ack); check("t1_d0_ack", ack, 0);
        i2c_write(8'h55, ack); check("t1_d1_ack", ack, 0);
        i2c_stop();
        #(T);
        check("t1_busy_after", busy, 0);
        check("t1_wr_count", wr_cnt - base, 2);
        check("t1_wr0_addr", wr_a[base], 8'h02);
        check("t1_wr0_data", wr_d[base], 8'hAA);
        check("t1_wr1_addr", wr_a[base+1], 8'h03);
        check("t1_wr1_data", wr_d[base+1], 8'h55);
        check("t1_ptr", dut.ptr, 4);

        // 2: pointer 6, repeated START, 3-byte read wrapping to reg 0
        rd_data[6*8 +: 8] = 8'h11; rd_data[7*8 +: 8] = 8'h22; rd_data[0*8 +: 8] = 8'h33;
        base = wr_cnt;
        i2c_start();
        i2c_write(8'hC8, ack); check("t2_addr_ack", ack, 0);
        i2c_write(8'h06, ack); check("t2_ptr_ack", ack, 0);
        i2c_start();
        i2c_write(8'hC9, ack); check("t2_raddr_ack", ack, 0);
        i2c_read(1'b0, 1'b0, b); check("t2_rd0", b, 8'h11);
        i2c_read(1'b0, 1'b0, b); check("t2_rd1", b, 8'h22);
        i2c_read(1'b1, 1'b0, b); check("t2_rd2", b, 8'h33);
        i2c_stop();
        #(T);
        check("t2_ptr", dut.ptr, 1);
        check("t2_no_wr", wr_cnt - base, 0);

        // 3: foreign address is ignored, next transfer works
        rd_data[1*8 +: 8] = 8'h5A;
        base = wr_cnt; oe_base = oe_cnt;
        i2c_start();
        i2c_write(8'hA0, ack); check("t3_nack", ack, 1);
        check("t3_busy_low", busy, 0);
        check("t3_oe_never", oe_cnt - oe_base, 0);
        check("t3_no_wr", wr_cnt - base, 0);
        i2c_start();
        i2c_write(8'hC9, ack); check("t3_addr_ack", ack, 0);
        i2c_read(1'b1, 1'b0, b); check("t3_rd", b, 8'h5A);
        i2c_stop();
        #(T);
        check("t3_ptr", dut.ptr, 2);

        // 4: out-of-range pointer is NACKed and leaves the pointer alone
        rd_data[2*8 +: 8] = 8'h77;
        i2c_start();
        i2c_write(8'hC8, ack); check("t4_addr_ack", ack, 0);
        i2c_write(8'h09, ack); check("t4_ptr_nack", ack, 1);
        i2c_stop();
        #(T);
        check("t4_ptr_kept", dut.ptr, 2);
        i2c_start();
        i2c_write(8'hC9, ack); check("t4_raddr_ack", ack, 0);
        i2c_read(1'b1, 1'b0, b); check("t4_rd_old", b, 8'h77);
        i2c_stop();
        #(T);

        // 5: register image is frozen at the address ACK
        base = wr_cnt;
        i2c_start();
        i2c_write(8'hC8, ack); check("t5_addr_ack", ack, 0);
        i2c_write(8'h00, ack); check("t5_ptr_ack", ack, 0);
        i2c_stop();
        #(T);
        check("t5_ptr_only", wr_cnt - base, 0);
        check("t5_ptr", dut.ptr, 0);
        rd_data[0*8 +: 8] = 8'h3C; rd_data[1*8 +: 8] = 8'h40;
        i2c_start();
        i2c_write(8'hC9, ack); check("t5_raddr_ack", ack, 0);
        i2c_read(1'b0, 1'b1, b); check("t5_rd0", b, 8'h3C);
        i2c_read(1'b1, 1'b0, b); check("t5_rd1_snap", b, 8'h40);
        i2c_stop();
        #(T);
        check("t5_ptr_end", dut.ptr, 2);

        // 6: reset while the slave holds SDA low for a 0 data bit
        rd_data[2*8 +: 8] = 8'h00;
        i2c_start();
        i2c_write(8'hC9, ack); check("t6_raddr_ack", ack, 0);
        check("t6_driving", sda_oe, 1);
        rst_n = 1'b0;
        #1;
        check("t6_oe_released", sda_oe, 0);
        check("t6_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("t6_oe_stays", sda_oe, 0);
        check("t6_ptr_reset", dut.ptr, 0);
        base = wr_cnt;
        i2c_start();
        i2c_write(8'hC8, ack); check("t6_addr_ack", ack, 0);
        i2c_write(8'h00, ack); check("t6_ptr_ack", ack, 0);
        i2c_write(8'h7E, ack); check("t6_d_ack", ack, 0);
        i2c_stop();
        #(T);
        check("t6_wr_count", wr_cnt - base, 1);
        check("t6_wr_addr", wr_a[base], 8'h00);
        check("t6_wr_data", wr_d[base], 8'h7E);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
